// File: rtl/counter_arbiter_pkg.sv
// Shared encodings for the two-requester saturating counter arbiter.
// The opcode and FSM state values live here so that both the top and the core use the same ones.
package counter_arbiter_pkg;

   typedef enum logic [1:0] {
      OP_READ = 2'b00,
      OP_UP   = 2'b01,
      OP_DOWN = 2'b10,
      OP_LOAD = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/counter_core.sv
// Saturating WIDTH-bit up/down/load register with HIGH/LOW flags.
// `sat` flags, for the op being presented, an UP at max or a DOWN at zero.
module counter_core
   import counter_arbiter_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  op_t              op,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] count,
   output logic             high,
   output logic             low,
   output logic             sat
);

   logic [WIDTH-1:0] count_q;

   assign count = count_q;
   assign high  = &count_q;
   assign low   = ~|count_q;
   assign sat   = ((op == OP_UP) && high) || ((op == OP_DOWN) && low);

   // UP and DOWN hold at the limits instead of wrapping around.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         count_q <= '0;
      end else if (en) begin
         case (op)
            OP_LOAD: count_q <= data;
            OP_UP:   if (!high) count_q <= count_q + WIDTH'(1);
            OP_DOWN: if (!low)  count_q <= count_q - WIDTH'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter for two requesters sharing one saturating counter.
// Each accepted command runs IDLE -> EXEC -> RESP and returns exactly one response.
module counter_arbiter
   import counter_arbiter_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ0_VALID,
   input  logic [1:0]       REQ0_OP,
   input  logic [WIDTH-1:0] REQ0_DATA,
   output logic             REQ0_READY,
   input  logic             REQ1_VALID,
   input  logic [1:0]       REQ1_OP,
   input  logic [WIDTH-1:0] REQ1_DATA,
   output logic             REQ1_READY,
   output logic             RSP_VALID,
   output logic             RSP_ID,
   output logic [WIDTH-1:0] RSP_VALUE,
   output logic             RSP_SAT,
   output logic [WIDTH-1:0] COUNT,
   output logic             HIGH,
   output logic             LOW,
   output logic [1:0]       DBG_STATE
);

   state_t           state, state_nxt;
   logic             last_q;
   logic             grant_id;
   logic             accept;
   logic             core_en;
   logic             core_sat;
   op_t              cmd_op_q;
   logic [WIDTH-1:0] cmd_data_q;
   logic             cmd_id_q;
   logic             rsp_id_q;
   logic             rsp_sat_q;

   // Handshake: a command transfers on a rising edge where VALID and READY are both high.
   // The requester holds VALID and payload stable until then; READY never waits on anything
   // but state, VALID and the last-grant pointer. Responses cannot be stalled.
   assign grant_id = REQ1_VALID && (!REQ0_VALID || !last_q);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      core_en    = 1'b0;
      REQ0_READY = 1'b0;
      REQ1_READY = 1'b0;
      case (state)
         ST_IDLE: begin
            if (REQ0_VALID || REQ1_VALID) begin
               accept     = 1'b1;
               REQ0_READY = !grant_id;
               REQ1_READY = grant_id;
               state_nxt  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            core_en   = 1'b1;
            state_nxt = ST_RESP;
         end
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         last_q     <= 1'b1;
         cmd_op_q   <= OP_READ;
         cmd_data_q <= '0;
         cmd_id_q   <= 1'b0;
         rsp_id_q   <= 1'b0;
         rsp_sat_q  <= 1'b0;
      end else begin
         if (accept) begin
            last_q     <= grant_id;
            cmd_op_q   <= op_t'(grant_id ? REQ1_OP : REQ0_OP);
            cmd_data_q <= grant_id ? REQ1_DATA : REQ0_DATA;
            cmd_id_q   <= grant_id;
         end
         // Response fields are only non-zero during the RESP cycle that follows EXEC.
         rsp_id_q  <= core_en ? cmd_id_q : 1'b0;
         rsp_sat_q <= core_en ? core_sat : 1'b0;
      end
   end

   counter_core #(.WIDTH(WIDTH)) u_core (
      .CLK   (CLK),
      .RST   (RST),
      .en    (core_en),
      .op    (cmd_op_q),
      .data  (cmd_data_q),
      .count (COUNT),
      .high  (HIGH),
      .low   (LOW),
      .sat   (core_sat)
   );

   assign RSP_VALID = (state == ST_RESP);
   assign RSP_ID    = rsp_id_q;
   assign RSP_SAT   = rsp_sat_q;
   assign RSP_VALUE = RSP_VALID ? COUNT : '0;
   assign DBG_STATE = state;

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: directed scenarios plus random commands,
// checked against a command-level model of the saturating counter and round-robin grant.
module tb_counter_arbiter;

   localparam int W    = 5;
   localparam int MAXV = (1 << W) - 1;
   localparam logic [1:0] C_READ = 2'b00, C_UP = 2'b01, C_DOWN = 2'b10, C_LOAD = 2'b11;

   logic         CLK, RST;
   logic         REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
   logic [1:0]   REQ0_OP, REQ1_OP;
   logic [W-1:0] REQ0_DATA, REQ1_DATA;
   logic         RSP_VALID, RSP_ID, RSP_SAT, HIGH, LOW;
   logic [W-1:0] RSP_VALUE, COUNT;
   logic [1:0]   DBG_STATE;

   int n_checks = 0;
   int n_errors = 0;
   int m_cnt    = 0;
   int m_last   = 1;
   logic [W-1:0] exp_q[$];
   logic         exp_id_q[$];

   counter_arbiter #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_OP(REQ0_OP), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
      .REQ1_VALID(REQ1_VALID), .REQ1_OP(REQ1_OP), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
      .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_VALUE(RSP_VALUE), .RSP_SAT(RSP_SAT),
      .COUNT(COUNT), .HIGH(HIGH), .LOW(LOW), .DBG_STATE(DBG_STATE)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   // reference model: command-level counter semantics and grant rule
   function automatic void model_exec(input logic [1:0] op, input int data, output int val, output logic sat);
      sat = 1'b0;
      case (op)
         C_UP:   if (m_cnt == MAXV) sat = 1'b1; else m_cnt = m_cnt + 1;
         C_DOWN: if (m_cnt == 0) sat = 1'b1; else m_cnt = m_cnt - 1;
         C_LOAD: m_cnt = data;
         default: ;
      endcase
      val = m_cnt;
   endfunction

   function automatic int model_grant(input logic v0, input logic v1);
      if (v0 && v1) return (m_last == 1) ? 0 : 1;
      return v1 ? 1 : 0;
   endfunction

   // driver: issue one command from one requester, report handshake and response timing
   task automatic send(input int id, input logic [1:0] op, input logic [W-1:0] data,
                       output int rdy_lat, output int rsp_lat,
                       output logic r_id, output logic [W-1:0] r_val, output logic r_sat);
      rdy_lat = -1; rsp_lat = -1; r_id = 1'b0; r_val = '0; r_sat = 1'b0;
      if (id == 0) begin REQ0_VALID = 1'b1; REQ0_OP = op; REQ0_DATA = data; end
      else         begin REQ1_VALID = 1'b1; REQ1_OP = op; REQ1_DATA = data; end
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         if ((id == 0) ? REQ0_READY : REQ1_READY) begin rdy_lat = c; break; end
         @(posedge CLK); #1;
      end
      if (rdy_lat >= 0) begin @(posedge CLK); #1; end
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      if (rdy_lat < 0) return;
      for (int k = 1; k < 8; k++) begin
         @(negedge CLK);
         if (RSP_VALID) begin rsp_lat = k; r_id = RSP_ID; r_val = RSP_VALUE; r_sat = RSP_SAT; break; end
         @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      RST = 1'b0; REQ0_VALID = 0; REQ1_VALID = 0; REQ0_OP = 0; REQ1_OP = 0; REQ0_DATA = 0; REQ1_DATA = 0;
      #23;
      n_checks++; if (COUNT !== '0) begin n_errors++; $display("FAIL reset_count: got %0d exp 0", COUNT); end
      n_checks++; if (LOW !== 1'b1 || HIGH !== 1'b0) begin n_errors++; $display("FAIL reset_flags: got low=%0b high=%0b exp low=1 high=0", LOW, HIGH); end
      n_checks++; if ({RSP_VALID, RSP_ID, RSP_SAT, RSP_VALUE} !== '0) begin n_errors++; $display("FAIL reset_rsp: got v=%0b id=%0b sat=%0b val=%0d exp all 0", RSP_VALID, RSP_ID, RSP_SAT, RSP_VALUE); end
      n_checks++; if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %0b%0b exp 00", REQ0_READY, REQ1_READY); end
      @(posedge CLK); #1;
      RST = 1'b1; m_cnt = 0; m_last = 1;
   endtask

   task automatic test_load_first();
      int rl, sl, ev; logic rid, rs, es; logic [W-1:0] rv;
      send(0, C_LOAD, W'(7), rl, sl, rid, rv, rs);
      model_exec(C_LOAD, 7, ev, es); m_last = 0; exp_q.push_back(W'(ev));
      n_checks++; if (rl !== 0) begin n_errors++; $display("FAIL first_ready_latency: got %0d exp 0", rl); end
      n_checks++; if (sl !== 2) begin n_errors++; $display("FAIL first_rsp_latency: got %0d exp 2", sl); end
      n_checks++; if (rid !== 1'b0) begin n_errors++; $display("FAIL first_rsp_id: got %0b exp 0", rid); end
      n_checks++; if (rv !== exp_q.pop_front()) begin n_errors++; $display("FAIL first_rsp_value: got %0d exp %0d", rv, ev); end
      n_checks++; if (rs !== es) begin n_errors++; $display("FAIL first_rsp_sat: got %0b exp %0b", rs, es); end
   endtask

   task automatic test_saturate();
      int rl, sl, ev; logic rid, rs, es; logic [W-1:0] rv;
      send(0, C_LOAD, W'(MAXV), rl, sl, rid, rv, rs); model_exec(C_LOAD, MAXV, ev, es); m_last = 0;
      send(1, C_UP, '0, rl, sl, rid, rv, rs); model_exec(C_UP, 0, ev, es); m_last = 1;
      n_checks++; if (rv !== W'(ev) || rs !== es) begin n_errors++; $display("FAIL sat_up: got val=%0d sat=%0b exp val=%0d sat=%0b", rv, rs, ev, es); end
      n_checks++; if (HIGH !== 1'b1 || COUNT !== W'(MAXV)) begin n_errors++; $display("FAIL sat_up_high: got high=%0b count=%0d exp high=1 count=%0d", HIGH, COUNT, MAXV); end
      n_checks++; if (rid !== 1'b1) begin n_errors++; $display("FAIL sat_up_id: got %0b exp 1", rid); end
      send(0, C_LOAD, '0, rl, sl, rid, rv, rs); model_exec(C_LOAD, 0, ev, es); m_last = 0;
      send(0, C_DOWN, '0, rl, sl, rid, rv, rs); model_exec(C_DOWN, 0, ev, es);
      n_checks++; if (rv !== W'(ev) || rs !== es) begin n_errors++; $display("FAIL sat_down: got val=%0d sat=%0b exp val=%0d sat=%0b", rv, rs, ev, es); end
      n_checks++; if (LOW !== 1'b1 || COUNT !== '0) begin n_errors++; $display("FAIL sat_down_low: got low=%0b count=%0d exp low=1 count=0", LOW, COUNT); end
   endtask

   task automatic test_read();
      int rl, sl, ev; logic rid, rs, es; logic [W-1:0] rv;
      send(0, C_LOAD, W'(12), rl, sl, rid, rv, rs); model_exec(C_LOAD, 12, ev, es); m_last = 0;
      send(0, C_READ, W'($urandom_range(0, MAXV)), rl, sl, rid, rv, rs); model_exec(C_READ, 0, ev, es);
      n_checks++; if (rv !== W'(ev) || rs !== es) begin n_errors++; $display("FAIL read_rsp: got val=%0d sat=%0b exp val=%0d sat=%0b", rv, rs, ev, es); end
      n_checks++; if (COUNT !== W'(ev)) begin n_errors++; $display("FAIL read_count: got %0d exp %0d", COUNT, ev); end
   endtask

   task automatic test_round_robin();
      int rl, sl, ev, g; logic rid, rs, es; logic [W-1:0] rv, xv; logic xid;
      send(1, C_LOAD, '0, rl, sl, rid, rv, rs); model_exec(C_LOAD, 0, ev, es); m_last = 1;
      REQ0_VALID = 1'b1; REQ0_OP = C_UP; REQ1_VALID = 1'b1; REQ1_OP = C_UP;
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK);
         if (c % 3 == 0) begin
            g = model_grant(1'b1, 1'b1);
            model_exec(C_UP, 0, ev, es); m_last = g;
            exp_q.push_back(W'(ev)); exp_id_q.push_back(g[0]);
            n_checks++; if (REQ0_READY !== (g == 0) || REQ1_READY !== (g == 1)) begin n_errors++; $display("FAIL rr_grant c%0d: got %0b%0b exp grant %0d", c, REQ0_READY, REQ1_READY, g); end
         end else begin
            n_checks++; if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin n_errors++; $display("FAIL rr_busy_ready c%0d: got %0b%0b exp 00", c, REQ0_READY, REQ1_READY); end
         end
         n_checks++; if (RSP_VALID !== (c % 3 == 2)) begin n_errors++; $display("FAIL rr_rsp_valid c%0d: got %0b exp %0b", c, RSP_VALID, (c % 3 == 2)); end
         if (c % 3 == 2) begin
            xv = exp_q.pop_front(); xid = exp_id_q.pop_front();
            n_checks++; if (RSP_VALUE !== xv || RSP_ID !== xid || RSP_SAT !== 1'b0) begin n_errors++; $display("FAIL rr_rsp c%0d: got id=%0b val=%0d sat=%0b exp id=%0b val=%0d sat=0", c, RSP_ID, RSP_VALUE, RSP_SAT, xid, xv); end
         end else begin
            n_checks++; if ({RSP_ID, RSP_SAT, RSP_VALUE} !== '0) begin n_errors++; $display("FAIL rr_rsp_idle c%0d: got id=%0b sat=%0b val=%0d exp 0", c, RSP_ID, RSP_SAT, RSP_VALUE); end
         end
         @(posedge CLK); #1;
      end
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_hold();
      int ev, g, n_rsp; logic es, got_id; logic [W-1:0] got_val, xv;
      REQ0_VALID = 1'b1; REQ0_OP = C_READ;
      @(negedge CLK);
      g = model_grant(1'b1, 1'b0);
      n_checks++; if (REQ0_READY !== 1'b1 || g != 0) begin n_errors++; $display("FAIL hold_req0_ready: got %0b exp 1", REQ0_READY); end
      model_exec(C_READ, 0, ev, es); m_last = 0; exp_q.push_back(W'(ev));
      @(posedge CLK); #1;
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b1; REQ1_OP = C_UP;
      @(negedge CLK);
      n_checks++; if (REQ1_READY !== 1'b0) begin n_errors++; $display("FAIL hold_exec_ready: got %0b exp 0", REQ1_READY); end
      @(posedge CLK); #1;
      @(negedge CLK);
      xv = exp_q.pop_front();
      n_checks++; if (REQ1_READY !== 1'b0) begin n_errors++; $display("FAIL hold_resp_ready: got %0b exp 0", REQ1_READY); end
      n_checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 1'b0 || RSP_VALUE !== xv) begin n_errors++; $display("FAIL hold_req0_rsp: got v=%0b id=%0b val=%0d exp v=1 id=0 val=%0d", RSP_VALID, RSP_ID, RSP_VALUE, xv); end
      @(posedge CLK); #1;
      @(negedge CLK);
      n_checks++; if (REQ1_READY !== 1'b1) begin n_errors++; $display("FAIL hold_idle_ready: got %0b exp 1", REQ1_READY); end
      model_exec(C_UP, 0, ev, es); m_last = 1;
      @(posedge CLK); #1;
      REQ1_VALID = 1'b0;
      n_rsp = 0; got_id = 1'b0; got_val = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         if (RSP_VALID) begin n_rsp++; got_id = RSP_ID; got_val = RSP_VALUE; end
         @(posedge CLK); #1;
      end
      n_checks++; if (n_rsp !== 1) begin n_errors++; $display("FAIL hold_rsp_count: got %0d exp 1", n_rsp); end
      n_checks++; if (got_id !== 1'b1 || got_val !== W'(ev)) begin n_errors++; $display("FAIL hold_req1_rsp: got id=%0b val=%0d exp id=1 val=%0d", got_id, got_val, ev); end
   endtask

   task automatic test_reset_mid();
      int rl, sl, ev, bad; logic rid, rs, es; logic [W-1:0] rv, d;
      send(0, C_LOAD, W'(20), rl, sl, rid, rv, rs); model_exec(C_LOAD, 20, ev, es); m_last = 0;
      REQ0_VALID = 1'b1; REQ0_OP = C_UP;
      @(negedge CLK);
      n_checks++; if (REQ0_READY !== 1'b1) begin n_errors++; $display("FAIL rstmid_accept: got %0b exp 1", REQ0_READY); end
      @(posedge CLK); #1;
      REQ0_VALID = 1'b0;
      RST = 1'b0;
      #1;
      n_checks++; if (COUNT !== '0 || LOW !== 1'b1 || HIGH !== 1'b0) begin n_errors++; $display("FAIL rstmid_count: got count=%0d low=%0b high=%0b exp 0/1/0", COUNT, LOW, HIGH); end
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         if (RSP_VALID !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL rstmid_no_rsp: got %0d strobes exp 0", bad); end
      @(posedge CLK); #1;
      RST = 1'b1; m_cnt = 0; m_last = 1;
      d = W'($urandom_range(1, MAXV));
      send(1, C_LOAD, d, rl, sl, rid, rv, rs); model_exec(C_LOAD, d, ev, es); m_last = 1;
      n_checks++; if (rl !== 0 || sl !== 2) begin n_errors++; $display("FAIL rstmid_after_lat: got rdy=%0d rsp=%0d exp 0/2", rl, sl); end
      n_checks++; if (rid !== 1'b1 || rv !== W'(ev) || rs !== es) begin n_errors++; $display("FAIL rstmid_after_rsp: got id=%0b val=%0d sat=%0b exp id=1 val=%0d sat=%0b", rid, rv, rs, ev, es); end
   endtask

   task automatic test_random();
      int rl, sl, ev, id, sel; logic rid, rs, es; logic [1:0] op; logic [W-1:0] rv, d;
      for (int i = 0; i < 30; i++) begin
         id  = $urandom_range(0, 1);
         op  = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 3);
         d   = (sel == 0) ? '0 : (sel == 1) ? W'(MAXV) : W'($urandom_range(0, MAXV));
         send(id, op, d, rl, sl, rid, rv, rs);
         model_exec(op, d, ev, es); m_last = id;
         n_checks++; if (rl !== 0 || sl !== 2) begin n_errors++; $display("FAIL rand%0d_lat: got rdy=%0d rsp=%0d exp 0/2", i, rl, sl); end
         n_checks++; if (rid !== id[0] || rv !== W'(ev) || rs !== es) begin n_errors++; $display("FAIL rand%0d_rsp op=%0d: got id=%0b val=%0d sat=%0b exp id=%0d val=%0d sat=%0b", i, op, rid, rv, rs, id, ev, es); end
         n_checks++; if (COUNT !== W'(ev) || HIGH !== (ev == MAXV) || LOW !== (ev == 0)) begin n_errors++; $display("FAIL rand%0d_count: got count=%0d high=%0b low=%0b exp %0d", i, COUNT, HIGH, LOW, ev); end
      end
   endtask

   initial begin
      test_reset();
      test_load_first();
      test_saturate();
      test_read();
      test_round_robin();
      test_hold();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter WIDTH, default 5, counter and data width in bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous active-low reset.
REQ-004 REQ0_VALID  input  1  requester 0 command valid.
REQ-005 REQ0_OP  input  2  requester 0 opcode: 00 READ, 01 UP, 10 DOWN, 11 LOAD.
REQ-006 REQ0_DATA  input  WIDTH  requester 0 load value; used only for LOAD.
REQ-007 REQ0_READY  output  1  requester 0 command accepted this cycle.
REQ-008 REQ1_VALID, REQ1_OP, REQ1_DATA, REQ1_READY: same directions, widths and meanings as REQ-004..007, for requester 1.
REQ-009 RSP_VALID  output  1  response strobe, one cycle per accepted command.
REQ-010 RSP_ID  output  1  requester index of the response.
REQ-011 RSP_VALUE  output  WIDTH  counter value after the command.
REQ-012 RSP_SAT  output  1  UP was refused at max, or DOWN was refused at zero.
REQ-013 COUNT  output  WIDTH  live counter value.
REQ-014 HIGH, LOW  output  1 each  COUNT == 2^WIDTH-1, COUNT == 0.

Function
REQ-015 FSM states: IDLE, EXEC, RESP.
REQ-016 IDLE: no VALID -> stay in IDLE.
REQ-017 IDLE: one or more VALID -> grant one requester, pulse its READY, latch OP/DATA/ID, go to EXEC.
REQ-018 Arbitration: round-robin with a 1-bit last-grant pointer; when both are valid, the requester not granted last wins; pointer resets to 1, so requester 0 wins first.
REQ-019 READY is combinational from state, VALID and pointer; it is high only in IDLE, and only for the granted requester.
REQ-020 EXEC: drive counter controls for exactly one cycle; counter updates on the EXEC->RESP edge; the FSM always goes to RESP.
REQ-021 Counter operations in EXEC:
- LOAD: COUNT <= DATA.
- UP: increment if not HIGH, else hold with SAT set.
- DOWN: decrement if not LOW, else hold with SAT set.
- READ: hold, SAT clear.
REQ-022 No wrap-around: COUNT never moves 0 -> max or max -> 0 through UP/DOWN.
REQ-023 RESP: RSP_VALID=1 for one cycle with RSP_ID, RSP_VALUE=COUNT (post-update) and RSP_SAT; the FSM returns to IDLE.
REQ-024 RSP_ID, RSP_VALUE and RSP_SAT are 0 whenever RSP_VALID=0.
REQ-025 Latency: accept cycle N, RSP_VALID in cycle N+2; maximum throughput is one command per 3 cycles.
REQ-026 Requests arriving in EXEC or RESP see READY=0 and are held by the requester (VALID stays asserted, payload stable).
REQ-027 No response backpressure; the consumer must take RSP in its valid cycle.
REQ-028 HIGH/LOW/COUNT are combinational from the counter register and valid in every state.

Reset
REQ-029 RST low forces FSM=IDLE, COUNT=0, pointer=1, latched command=0, and RSP_VALID=RSP_SAT=RSP_ID=RSP_VALUE=0, regardless of CLK.
REQ-030 Reset mid-command drops that command with no response; after reset, LOW=1 and HIGH=0.
REQ-031 First acceptance is possible in the first CLK edge after RST deasserts.

Structure
REQ-032 Shared package holds the opcode encodings (READ/UP/DOWN/LOAD) and the FSM state encoding.
REQ-033 One sub-module, counter_core: the saturating WIDTH-bit up/down/load register with async active-low reset, plus HIGH/LOW flags.
REQ-034 counter_arbiter contains only the arbiter, FSM and response register, and instantiates counter_core once.

Verification
REQ-035 Reset, then REQ0 LOAD 7 -> REQ0_READY in cycle 1; RSP_VALID cycle 3 with ID=0, VALUE=7, SAT=0.
REQ-036 COUNT=31, REQ1 UP -> RSP VALUE=31, SAT=1, HIGH=1; COUNT=0, REQ0 DOWN -> VALUE=0, SAT=1, LOW=1.
REQ-037 Both VALID held continuously, both issuing UP from 0 -> grants alternate 0,1,0,1; responses VALUE=1,2,3,4, each 3 cycles apart.
REQ-038 REQ1 raises VALID during EXEC of a REQ0 command -> REQ1_READY=0 until the next IDLE; then accepted, with exactly one response.
REQ-039 RST asserted during EXEC -> no RSP_VALID; COUNT=0 immediately; next command after release executes normally.
REQ-040 REQ0 READ at COUNT=12 -> VALUE=12, SAT=0, COUNT unchanged.
